// File: rtl/line_step_ctrl.sv
// Two-axis line stepper: Bresenham over |dx|,|dy| emitting handshaked X/Y step
// requests. A single saturating magnitude unit is time-shared across both deltas.
module line_step_ctrl #(
  parameter int NUM_BITS = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [NUM_BITS-1:0] dx,
  input  logic [NUM_BITS-1:0] dy,
  output logic                rdy,
  output logic                step_x,
  output logic                step_y,
  output logic                dir_x,
  output logic                dir_y,
  input  logic                step_ack,
  output logic                done
);
  localparam int MW = NUM_BITS - 1;
  localparam int EW = NUM_BITS + 2;

  typedef enum logic [2:0] {IDLE, ABS_X, ABS_Y, INIT, STEP, WAIT_ACK, DONE} state_t;
  state_t r_state, w_state_nxt;

  logic [NUM_BITS-1:0] r_dx, r_dy, w_abs_in;
  logic [MW-1:0]       w_abs_out, r_adx, r_ady, r_rem_x, r_rem_y, w_rem_x_nxt, w_rem_y_nxt;
  logic signed [EW-1:0] r_err, w_adx_e, w_ady_e, w_err_nxt;
  logic signed [EW:0]   w_e2, w_adx_c, w_ady_c;
  logic w_sx, w_sy, r_step_x, r_step_y, r_dir_x, r_dir_y, r_done;

  assign w_abs_in = (r_state == ABS_Y) ? r_dy : r_dx;

  line_step_abs #(.NUM_BITS(NUM_BITS)) u_abs (
    .i_val (w_abs_in),
    .o_mag (w_abs_out)
  );

  assign w_adx_e = $signed({{(EW-MW){1'b0}}, r_adx});
  assign w_ady_e = $signed({{(EW-MW){1'b0}}, r_ady});
  assign w_adx_c = $signed({{(EW+1-MW){1'b0}}, r_adx});
  assign w_ady_c = $signed({{(EW+1-MW){1'b0}}, r_ady});
  assign w_e2    = $signed({r_err, 1'b0});

  assign w_sx = (w_e2 > -w_ady_c) && (r_rem_x != '0);
  assign w_sy = (w_e2 <  w_adx_c) && (r_rem_y != '0);

  // The registered step bits double as the remembered sx/sy for the ack update.
  assign w_err_nxt   = r_err - (r_step_x ? w_ady_e : {EW{1'b0}})
                             + (r_step_y ? w_adx_e : {EW{1'b0}});
  assign w_rem_x_nxt = r_rem_x - MW'(r_step_x);
  assign w_rem_y_nxt = r_rem_y - MW'(r_step_y);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:     if (start) w_state_nxt = ABS_X;
      ABS_X:    w_state_nxt = ABS_Y;
      ABS_Y:    w_state_nxt = INIT;
      INIT:     w_state_nxt = (r_adx == '0 && r_ady == '0) ? DONE : STEP;
      STEP:     w_state_nxt = WAIT_ACK;
      WAIT_ACK: if (step_ack)
                  w_state_nxt = (w_rem_x_nxt == '0 && w_rem_y_nxt == '0) ? DONE : STEP;
      DONE:     w_state_nxt = IDLE;
      default:  w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dx     <= '0;
      r_dy     <= '0;
      r_adx    <= '0;
      r_ady    <= '0;
      r_rem_x  <= '0;
      r_rem_y  <= '0;
      r_err    <= '0;
      r_step_x <= 1'b0;
      r_step_y <= 1'b0;
      r_dir_x  <= 1'b0;
      r_dir_y  <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= (r_state == DONE);
      case (r_state)
        IDLE: if (start) begin
          r_dx    <= dx;
          r_dy    <= dy;
          r_dir_x <= dx[NUM_BITS-1];
          r_dir_y <= dy[NUM_BITS-1];
        end
        ABS_X: r_adx <= w_abs_out;
        ABS_Y: r_ady <= w_abs_out;
        INIT: begin
          r_rem_x <= r_adx;
          r_rem_y <= r_ady;
          r_err   <= w_adx_e - w_ady_e;
        end
        STEP: begin
          r_step_x <= w_sx;
          r_step_y <= w_sy;
        end
        WAIT_ACK: if (step_ack) begin
          r_step_x <= 1'b0;
          r_step_y <= 1'b0;
          r_err    <= w_err_nxt;
          r_rem_x  <= w_rem_x_nxt;
          r_rem_y  <= w_rem_y_nxt;
        end
        default: ;
      endcase
    end
  end

  assign rdy    = (r_state == IDLE);
  assign step_x = r_step_x;
  assign step_y = r_step_y;
  assign dir_x  = r_dir_x;
  assign dir_y  = r_dir_y;
  assign done   = r_done;
endmodule

// Magnitude of a signed value; the most negative input saturates to all ones.
module line_step_abs #(
  parameter int NUM_BITS = 8
) (
  input  logic [NUM_BITS-1:0] i_val,
  output logic [NUM_BITS-2:0] o_mag
);
  logic [NUM_BITS-1:0] w_neg;
  assign w_neg = -i_val;

  always_comb begin
    o_mag = i_val[NUM_BITS-2:0];
    if (i_val[NUM_BITS-1]) o_mag = w_neg[NUM_BITS-1] ? '1 : w_neg[NUM_BITS-2:0];
  end
endmodule

// File: tb/tb_line_step_ctrl.sv
// Directed bench for line_step_ctrl: segment table plus reset corner sequences.
module tb_line_step_ctrl;
  localparam int NB = 8;

  logic          clk = 1'b0, reset_n = 1'b0, start = 1'b0, step_ack = 1'b0;
  logic [NB-1:0] dx = '0, dy = '0;
  logic          rdy, step_x, step_y, dir_x, dir_y, done;
  int            n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  line_step_ctrl #(.NUM_BITS(NB)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .dx       (dx),
    .dy       (dy),
    .rdy      (rdy),
    .step_x   (step_x),
    .step_y   (step_y),
    .dir_x    (dir_x),
    .dir_y    (dir_y),
    .step_ack (step_ack),
    .done     (done)
  );

  typedef struct {
    logic [7:0]  dx, dy;
    int          ackdly;
    bit          hold;
    int          nx, ny, nst;
    logic        dirx, diry;
    logic [15:0] seq;   // 2 bits per step {y,x}, step 0 in LSBs
    bit          chkseq;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic run_seg(input string tag, input logic [7:0] idx, input logic [7:0] idy,
                         input int ackdly, input bit hold,
                         output int nx, output int ny, output int nst, output int ndone,
                         output int first, output int rdy_bad, output int dir_bad,
                         output logic [15:0] seq, output logic fdx, output logic fdy);
    int cyc, wcnt;
    bit pend;
    logic [1:0] pat, cur;
    nx = 0; ny = 0; nst = 0; ndone = 0; first = -1; rdy_bad = 0; dir_bad = 0;
    seq = '0; fdx = 1'b0; fdy = 1'b0; pend = 1'b0; wcnt = 0; cur = '0;
    @(posedge clk); #1;
    start = 1'b1; dx = idx; dy = idy;
    @(posedge clk); #1;
    if (hold) begin dx = 8'h07; dy = 8'h07; end
    else start = 1'b0;
    cyc = 0;
    while (cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
      if (done) begin
        ndone++;
        if (first < 0) first = cyc;
        break;
      end
      if (rdy) rdy_bad++;
      pat = {step_y, step_x};
      if (pat != 2'b00) begin
        if (!pend) begin
          pend = 1'b1; wcnt = 0; cur = pat;
          if (first < 0) first = cyc;
          if (nst < 8) seq[2*nst +: 2] = pat;
          if (nst == 0) begin fdx = dir_x; fdy = dir_y; end
          nx += int'(step_x); ny += int'(step_y); nst++;
        end else if (pat != cur) dir_bad++;
        if (dir_x !== fdx || dir_y !== fdy) dir_bad++;
        wcnt++;
        step_ack = (wcnt >= ackdly);
      end else begin
        pend = 1'b0;
        step_ack = 1'b0;
      end
    end
    start = 1'b0; step_ack = 1'b0;
    @(posedge clk); #1;
    if (done) ndone++;
    chk({tag, " rdy after done"}, 32'(rdy), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int nx, ny, nst, ndone, first, rdy_bad, dir_bad, cyc;
    logic [15:0] seq;
    logic fdx, fdy;
    string tag;

    vecs[0] = '{dx:8'h03, dy:8'h00, ackdly:1, hold:0, nx:3,   ny:0, nst:3,   dirx:0, diry:0, seq:16'h0015, chkseq:1};
    vecs[1] = '{dx:8'hFD, dy:8'hFD, ackdly:1, hold:0, nx:3,   ny:3, nst:3,   dirx:1, diry:1, seq:16'h003F, chkseq:1};
    vecs[2] = '{dx:8'h05, dy:8'hFE, ackdly:2, hold:0, nx:5,   ny:2, nst:5,   dirx:0, diry:1, seq:16'h01DD, chkseq:1};
    vecs[3] = '{dx:8'h00, dy:8'h00, ackdly:1, hold:0, nx:0,   ny:0, nst:0,   dirx:0, diry:0, seq:16'h0000, chkseq:1};
    vecs[4] = '{dx:8'h80, dy:8'h00, ackdly:1, hold:0, nx:127, ny:0, nst:127, dirx:1, diry:0, seq:16'h0000, chkseq:0};
    vecs[5] = '{dx:8'h02, dy:8'h07, ackdly:3, hold:0, nx:2,   ny:7, nst:7,   dirx:0, diry:0, seq:16'h2EAE, chkseq:1};
    vecs[6] = '{dx:8'h02, dy:8'h00, ackdly:1, hold:1, nx:2,   ny:0, nst:2,   dirx:0, diry:0, seq:16'h0005, chkseq:1};

    // Reset state, sampled while reset is held
    #12;
    chk("reset rdy",    32'(rdy),    32'd1);
    chk("reset step_x", 32'(step_x), 32'd0);
    chk("reset step_y", 32'(step_y), 32'd0);
    chk("reset dir_x",  32'(dir_x),  32'd0);
    chk("reset dir_y",  32'(dir_y),  32'd0);
    chk("reset done",   32'(done),   32'd0);
    #10 reset_n = 1'b1;

    foreach (vecs[i]) begin
      tag = $sformatf("v%0d", i);
      run_seg(tag, vecs[i].dx, vecs[i].dy, vecs[i].ackdly, vecs[i].hold,
              nx, ny, nst, ndone, first, rdy_bad, dir_bad, seq, fdx, fdy);
      chk({tag, " x steps"},    32'(nx),      32'(vecs[i].nx));
      chk({tag, " y steps"},    32'(ny),      32'(vecs[i].ny));
      chk({tag, " step count"}, 32'(nst),     32'(vecs[i].nst));
      chk({tag, " done count"}, 32'(ndone),   32'd1);
      chk({tag, " latency"},    32'(first),   32'd4);
      chk({tag, " rdy busy"},   32'(rdy_bad), 32'd0);
      chk({tag, " hold"},       32'(dir_bad), 32'd0);
      if (vecs[i].nst > 0) begin
        chk({tag, " dir_x"}, 32'(fdx), 32'(vecs[i].dirx));
        chk({tag, " dir_y"}, 32'(fdy), 32'(vecs[i].diry));
      end
      if (vecs[i].chkseq) chk({tag, " order"}, 32'(seq), 32'(vecs[i].seq));
    end

    // Reset in WAIT_ACK with the ack withheld
    @(posedge clk); #1;
    start = 1'b1; dx = 8'hFD; dy = 8'hFD;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (cyc < 20 && !(step_x || step_y)) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("mid step seen", 32'({step_y, step_x}), 32'd3);
    @(posedge clk); #1;
    chk("mid step held", 32'({step_y, step_x}), 32'd3);
    chk("mid dir_x",     32'(dir_x), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst step_x", 32'(step_x), 32'd0);
    chk("rst step_y", 32'(step_y), 32'd0);
    chk("rst dir_x",  32'(dir_x),  32'd0);
    chk("rst dir_y",  32'(dir_y),  32'd0);
    chk("rst rdy",    32'(rdy),    32'd1);
    chk("rst done",   32'(done),   32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst held steps", 32'({step_y, step_x}), 32'd0);
    chk("rst held rdy",   32'(rdy), 32'd1);
    reset_n = 1'b1;

    run_seg("post", 8'h01, 8'h01, 1, 1'b0,
            nx, ny, nst, ndone, first, rdy_bad, dir_bad, seq, fdx, fdy);
    chk("post x steps",    32'(nx),    32'd1);
    chk("post y steps",    32'(ny),    32'd1);
    chk("post step count", 32'(nst),   32'd1);
    chk("post order",      32'(seq),   32'd3);
    chk("post done count", 32'(ndone), 32'd1);
    chk("post latency",    32'(first), 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/line_step_ctrl.md
LINE_STEP_CTRL -- requirements
Module: line_step_ctrl

Interface
REQ-001 SHALL have parameter NUM_BITS, default 8 (`BYTE_BITS`), the width of the signed two's-complement delta inputs.
REQ-002 SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, a request to draw one line segment.
REQ-005 SHALL have port dx, input, NUM_BITS, signed X delta.
REQ-006 SHALL have port dy, input, NUM_BITS, signed Y delta.
REQ-007 SHALL have port rdy, output, 1, high when idle and able to accept start.
REQ-008 SHALL have port step_x, output, 1, X step request.
REQ-009 SHALL have port step_y, output, 1, Y step request.
REQ-010 SHALL have port dir_x, output, 1; 1 means negative X.
REQ-011 SHALL have port dir_y, output, 1; 1 means negative Y.
REQ-012 SHALL have port step_ack, input, 1, downstream motor driver consumed the current step.
REQ-013 SHALL have port done, output, 1, a one-cycle segment-complete pulse.

Function
REQ-014 SHALL instantiate exactly one Abs (NUM_BITS) and time-share it between dx and dy through an operand mux selected by state.
REQ-015 SHALL use states IDLE, ABS_X, ABS_Y, INIT, STEP, WAIT_ACK and DONE.
REQ-016 SHALL assert rdy only in IDLE (combinational from state).
REQ-017 SHALL, in IDLE with start=1 at a clock edge, latch dx/dy, set dir_x=dx[MSB] and dir_y=dy[MSB], and go to ABS_X.
REQ-018 SHALL ignore start in every state except IDLE.
REQ-019 SHALL, in ABS_X, register adx = Abs(dx_reg) and go to ABS_Y; in ABS_Y, register ady = Abs(dy_reg) and go to INIT.
REQ-020 SHALL saturate the magnitude of input -2^(NUM_BITS-1) to 2^(NUM_BITS-1)-1 (NUM_BITS-1 bits).
REQ-021 SHALL, in INIT, load rem_x=adx, rem_y=ady and err=adx-ady (signed, NUM_BITS+2 bits), then go to DONE if both are zero, else to STEP.
REQ-022 SHALL, in STEP, compute e2=2*err and decide: sx = (e2 > -ady) AND rem_x!=0; sy = (e2 < adx) AND rem_y!=0.
REQ-023 SHALL, on leaving STEP, register step_x=sx and step_y=sy and go to WAIT_ACK.
REQ-024 SHALL, in WAIT_ACK, hold step_x, step_y, dir_x and dir_y stable until step_ack=1 is sampled.
REQ-025 SHALL, on that edge, clear step_x/step_y, apply err -= ady if sx and err += adx if sy (both when both), and decrement each stepped rem.
REQ-026 SHALL, after the step_ack edge, go to DONE if both rems are zero, else to STEP; step outputs are therefore low for at least one cycle between steps.
REQ-027 SHALL ignore step_ack outside WAIT_ACK.
REQ-028 SHALL assert done for exactly one cycle in DONE, then return to IDLE.
REQ-029 SHALL keep dir_x/dir_y valid from ABS_X through DONE; they may hold stale values in IDLE.
REQ-030 SHALL meet this latency: start sampled at edge 0; step outputs visible after edge 4; zero-length segment gives done high after edge 4.
REQ-031 SHALL emit exactly adx X-steps and ady Y-steps per segment.

Reset
REQ-032 SHALL, while reset_n=0 and regardless of clk, force state IDLE, step_x=step_y=0, dir_x=dir_y=0, done=0, clear all internal registers, and hold rdy=1.
REQ-033 SHALL, on reset asserted mid-segment, abandon the segment with no further steps and accept a fresh start normally after release.

Verification
REQ-034 SHALL cover: dx=3, dy=0, ack 1 cycle after each step -> 3 step_x pulses, step_y never, dir_x=0, one done.
REQ-035 SHALL cover: dx=-3, dy=-3 -> 3 pulses with step_x and step_y together, dir_x=dir_y=1.
REQ-036 SHALL cover: dx=5, dy=-2 -> step order X, XY, X, XY, X; dir_y=1; totals 5 X and 2 Y.
REQ-037 SHALL cover: dx=0, dy=0 -> no steps; done high after edge 4; rdy high again the following cycle.
REQ-038 SHALL cover: dx=-128, dy=0 at NUM_BITS=8 -> exactly 127 X-steps, dir_x=1.
REQ-039 SHALL cover: reset_n pulsed low during WAIT_ACK with step_ack withheld, then start with dx=1, dy=1 -> outputs cleared and rdy=1 immediately, then exactly one XY step and done.
